// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite list packer: entry layout, commit FSM states, register map.
package sprite_pkg;

   localparam int unsigned NUM_SPRITES_DEF = 20;
   localparam int unsigned ENTRY_W_DEF     = 24;
   localparam int unsigned BUNDLE_W_DEF    = 512;

   localparam logic [4:0] ADDR_COMMIT = 5'd20;
   localparam logic [4:0] ADDR_STATUS = 5'd21;

   typedef struct packed {
      logic [3:0] id;
      logic [9:0] x;
      logic [9:0] y;
   } sprite_entry_t;

   typedef enum logic [1:0] {IDLE, ARMED, PUSH} packer_state_t;

   function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic pending);
      return {16'h0000, cnt, 7'b0000000, pending};
   endfunction

endpackage

// File: rtl/sprite_commit_fsm.sv
// Commit sequencer: arms on COMMIT, snapshots on the next frame start, strobes gl_write for one
// cycle and counts completed pushes.
module sprite_commit_fsm
   import sprite_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       commit_wr,
   input  logic       frame_start,
   output logic       pending,
   output logic       snapshot,
   output logic       gl_write,
   output logic [7:0] commit_cnt
);

   packer_state_t state_q, state_d;
   logic [7:0]    cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // COMMIT writes seen while ARMED fall through unchanged: they merge into the pending push.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit_wr) state_d = ARMED;
         ARMED:   if (frame_start) state_d = PUSH;
         PUSH:    state_d = commit_wr ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pending  = (state_q == ARMED);
      snapshot = (state_q == ARMED) && frame_start;
      gl_write = (state_q == PUSH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (state_q == PUSH) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign commit_cnt = cnt_q;

endmodule

// File: rtl/sprite_list_packer.sv
// Avalon-MM sprite shadow table with frame-synchronised bundle push to the VGA block.
// Optional: define SPRITE_READBACK_EN to make slot entries readable over the bus.
module sprite_list_packer
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = NUM_SPRITES_DEF,
   parameter int unsigned ENTRY_W     = ENTRY_W_DEF,
   parameter int unsigned BUNDLE_W    = BUNDLE_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chipselect,
   input  logic                write,
   input  logic                read,
   input  logic [4:0]          address,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic                frame_start,
   output logic [BUNDLE_W-1:0] gl_data,
   output logic                gl_write
);

   sprite_entry_t       shadow_q [NUM_SPRITES];
   logic [BUNDLE_W-1:0] packed_bundle;
   logic [BUNDLE_W-1:0] gl_data_q;
   logic [31:0]         rdata_d, rdata_q;
   logic                slot_wr, commit_wr;
   logic                pending, snapshot;
   logic [7:0]          commit_cnt;
   logic                unused_wdata;

   assign unused_wdata = ^writedata[31:24];

   assign slot_wr   = chipselect && write && ({27'd0, address} < NUM_SPRITES);
   assign commit_wr = chipselect && write && (address == ADDR_COMMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '{default: '0};
      end else if (slot_wr) begin
         shadow_q[address] <= sprite_entry_t'(writedata[23:0]);
      end
   end

   always_comb begin
      packed_bundle = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         packed_bundle[i*ENTRY_W +: ENTRY_W] = shadow_q[i];
      end
   end

   // Snapshot uses the pre-edge table, so a slot write on the same edge lands in the next push.
   always_ff @(posedge clk) begin
      if (reset) begin
         gl_data_q <= '0;
      end else if (snapshot) begin
         gl_data_q <= packed_bundle;
      end
   end

   sprite_commit_fsm u_fsm (
      .clk         (clk),
      .reset       (reset),
      .commit_wr   (commit_wr),
      .frame_start (frame_start),
      .pending     (pending),
      .snapshot    (snapshot),
      .gl_write    (gl_write),
      .commit_cnt  (commit_cnt)
   );

   always_comb begin
      rdata_d = 32'd0;
      if (address == ADDR_STATUS) begin
         rdata_d = status_word(commit_cnt, pending);
      end
`ifdef SPRITE_READBACK_EN
      else if ({27'd0, address} < NUM_SPRITES) begin
         rdata_d = {8'd0, shadow_q[address]};
      end
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 32'd0;
      end else if (chipselect && read) begin
         rdata_q <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign gl_data  = gl_data_q;

endmodule

// File: tb/tb_sprite_list_packer.sv
// Scoreboard bench for sprite_list_packer: directed scenarios plus random bus/frame traffic.
module tb_sprite_list_packer;

   logic         clk = 1'b0;
   logic         reset;
   logic         chipselect, write, read, frame_start;
   logic [4:0]   address;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic [511:0] gl_data;
   logic         gl_write;

   sprite_list_packer dut (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (chipselect),
      .write       (write),
      .read        (read),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .frame_start (frame_start),
      .gl_data     (gl_data),
      .gl_write    (gl_write)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model of the software-visible behaviour.
   logic [23:0]  m_shadow [20];
   logic         m_pending;
   logic         m_push;
   logic [7:0]   m_cnt;
   logic [511:0] m_last;

   logic [511:0] exp_bundle_q [$];
   logic [31:0]  exp_read_q [$];
   logic         rd_fire = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] model_pack();
      logic [511:0] b = '0;
      for (int i = 0; i < 20; i++) b[24*i +: 24] = m_shadow[i];
      return b;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd21) return {16'h0, m_cnt, 7'h0, m_pending};
`ifdef SPRITE_READBACK_EN
      if (a < 5'd20) return {8'h0, m_shadow[a]};
`endif
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 20; i++) m_shadow[i] = 24'h0;
      m_pending = 1'b0;
      m_push    = 1'b0;
      m_cnt     = 8'h0;
      m_last    = '0;
   endtask

   // One bus cycle: drive, take the edge, then advance the model by the same rules.
   task automatic bus(input logic cs, input logic wr, input logic rd, input logic [4:0] a,
                      input logic [31:0] wd, input logic fs);
      logic commit, slotw;
      chipselect  = cs;
      write       = wr;
      read        = rd;
      address     = a;
      writedata   = wd;
      frame_start = fs;
      if (cs && rd) exp_read_q.push_back(model_read(a));
      commit = cs && wr && (a == 5'd20);
      slotw  = cs && wr && (a < 5'd20);
      @(posedge clk);
      if (m_push) begin
         m_cnt++;
         m_push    = 1'b0;
         m_pending = commit;
      end else if (m_pending) begin
         if (fs) begin
            m_last = model_pack();
            exp_bundle_q.push_back(m_last);
            m_push    = 1'b1;
            m_pending = 1'b0;
         end
      end else if (commit) begin
         m_pending = 1'b1;
      end
      if (slotw) m_shadow[a] = wd[23:0];
      @(negedge clk);
      chipselect  = 1'b0;
      write       = 1'b0;
      read        = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
   endtask

   task automatic wr_slot(input logic [4:0] a, input logic [31:0] d, input logic fs);
      bus(1'b1, 1'b1, 1'b0, a, d, fs);
   endtask

   task automatic commit(input logic fs);
      bus(1'b1, 1'b1, 1'b0, 5'd20, 32'hDEAD_BEEF, fs);
   endtask

   task automatic rd_addr(input logic [4:0] a);
      bus(1'b1, 1'b0, 1'b1, a, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      exp_bundle_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(posedge clk) rd_fire <= chipselect && read && !reset;

   always @(negedge clk) begin
      if (gl_write) begin
         if (exp_bundle_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_gl_write: got strobe expected none");
         end else begin
            check("gl_data_push", gl_data, exp_bundle_q.pop_front());
         end
      end
      if (rd_fire) begin
         if (exp_read_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL readdata_no_expect: got %0h expected none", readdata);
         end else begin
            check("readdata", {480'h0, readdata}, {480'h0, exp_read_q.pop_front()});
         end
      end
   end

   initial begin
      chipselect = 0; write = 0; read = 0; address = 0; writedata = 0; frame_start = 0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // Reset state
      check("reset_gl_data", gl_data, '0);
      check("reset_gl_write", {511'h0, gl_write}, '0);
      rd_addr(5'd21);

      // Basic commit and push
      wr_slot(5'd0, 32'hFF12_3456, 1'b0);
      wr_slot(5'd19, 32'h00AB_CDEF, 1'b0);
      commit(1'b0);
      rd_addr(5'd21);
      idle(1);
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(2);
      check("bundle_slot0", {488'h0, gl_data[23:0]}, {488'h0, 24'h123456});
      check("bundle_slot19", {488'h0, gl_data[479:456]}, {488'h0, 24'hABCDEF});
      check("bundle_upper_zero", {480'h0, gl_data[511:480]}, '0);
      rd_addr(5'd21);

      // Slot writes and frame starts without COMMIT: no push, gl_data holds
      wr_slot(5'd7, 32'h0055_5555, 1'b1);
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(2);
      check("hold_no_commit", gl_data, m_last);

      // Merged commits
      do_reset();
      commit(1'b0); commit(1'b0); commit(1'b0);
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(1);
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(2);
      rd_addr(5'd21);

      // Slot write on the snapshot edge goes to the next push
      commit(1'b0);
      wr_slot(5'd3, 32'h0000_0111, 1'b0);
      wr_slot(5'd3, 32'h0000_0222, 1'b1);
      idle(2);
      check("snap_old_value", {488'h0, gl_data[95:72]}, {488'h0, 24'h000111});
      commit(1'b0);
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(2);
      check("snap_new_value", {488'h0, gl_data[95:72]}, {488'h0, 24'h000222});

      // COMMIT with frame_start in IDLE arms only; reset while armed drops the push
      commit(1'b1);
      idle(2);
      rd_addr(5'd21);
      do_reset();
      bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      idle(2);
      check("reset_drops_push", gl_data, '0);

      // Counter wrap, readback and ignored address
      for (int r = 0; r < 256; r++) begin
         commit(1'b0);
         bus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
         idle(1);
      end
      rd_addr(5'd21);
      wr_slot(5'd5, 32'hEE07_ABCD, 1'b0);
      rd_addr(5'd5);
      wr_slot(5'd25, 32'h1234_5678, 1'b0);
      rd_addr(5'd25);
      rd_addr(5'd20);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         bus(op != 3'd0, op inside {[3'd1:3'd4]}, op inside {[3'd5:3'd7]},
             (op == 3'd2) ? 5'd20 : 5'($urandom_range(0, 31)), $urandom(),
             ($urandom_range(0, 5) == 0));
      end
      idle(4);
      check("push_queue_drained", {480'h0, 32'(exp_bundle_q.size())}, '0);
      check("read_queue_drained", {480'h0, 32'(exp_read_q.size())}, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
